// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive engine: bit-time table, FSM states and counter widths.
package uart_pkg;

    localparam int BAUD_CNT_W = 19;
    localparam int BIT_CNT_W  = 4;
    localparam int SHREG_W    = 9;

    // Bit time in clk cycles at 100 MHz, indexed by the BAUD select code.
    localparam logic [BAUD_CNT_W-1:0] BAUD_TABLE [16] = '{
        19'd333333, 19'd83333, 19'd41667, 19'd20833,
        19'd10417,  19'd5208,  19'd2604,  19'd1736,
        19'd868,    19'd434,   19'd217,   19'd109,
        19'd333333, 19'd333333, 19'd333333, 19'd333333
    };

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        STOP,
        DONE
    } rx_state_e;

    function automatic logic [BAUD_CNT_W-1:0] bit_time(input logic [3:0] code);
        return BAUD_TABLE[code];
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-time down-counter: loads a full or half bit time and pulses done_o when it expires.
module uart_baud_timer
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       half_i,
    input  logic [3:0] baud_i,
    output logic       done_o
);

    logic [BAUD_CNT_W-1:0] cnt_q, cnt_d, load_val;
    logic                  active_q, active_d;

    // done_o fires exactly N cycles after a load of N, so a reload on done keeps bit spacing exact.
    always_comb begin
        load_val = half_i ? (bit_time(baud_i) >> 1) : bit_time(baud_i);
        done_o   = active_q && (cnt_q == BAUD_CNT_W'(1));
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load_i) begin
            cnt_d    = load_val;
            active_d = 1'b1;
        end else if (done_o) begin
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (active_q) begin
            cnt_d = cnt_q - BAUD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: synchronizer, frame FSM, shift register and status flags.
// Overrun reporting on OVF is built only when UART_RX_OVERRUN_EN is defined.
module uart_rx_engine
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] BAUD,
    input  logic       EIGHT,
    input  logic       PEN,
    input  logic       OHEL,
    input  logic       RX,
    input  logic       READ,
    output logic [7:0] DATA,
    output logic       RXRDY,
    output logic       PERR,
    output logic       FERR,
    output logic       OVF
);

    rx_state_e              state_q, state_d;
    logic                   sync1_q, sync2_q, rx_prev_q;
    logic [3:0]             baud_q, baud_d;
    logic                   eight_q, eight_d, pen_q, pen_d, ohel_q, ohel_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d, nbits;
    logic [SHREG_W-1:0]     shreg_q, shreg_d, aligned;
    logic                   stop_q, stop_d;
    logic [7:0]             data_q, data_d;
    logic                   rxrdy_q, rxrdy_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                   tmr_load, tmr_half, tmr_done, par_bit;
    logic [3:0]             tmr_baud;

    assign nbits   = BIT_CNT_W'(7) + BIT_CNT_W'(eight_q) + BIT_CNT_W'(pen_q);
    // Right-justify the received bits so data starts at bit 0 whatever the frame length.
    assign aligned = shreg_q >> (BIT_CNT_W'(SHREG_W) - nbits);
    assign par_bit = eight_q ? aligned[8] : aligned[7];
    assign tmr_baud = (state_q == IDLE) ? BAUD : baud_q;

    uart_baud_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (tmr_load),
        .half_i (tmr_half),
        .baud_i (tmr_baud),
        .done_o (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        eight_d   = eight_q;
        pen_d     = pen_q;
        ohel_d    = ohel_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        stop_d    = stop_q;
        data_d    = data_q;
        rxrdy_d   = rxrdy_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        tmr_load  = 1'b0;
        tmr_half  = 1'b0;
        if (READ && rxrdy_q) begin
            rxrdy_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (!sync2_q && rx_prev_q) begin
                    state_d   = START;
                    baud_d    = BAUD;
                    eight_d   = EIGHT;
                    pen_d     = PEN;
                    ohel_d    = OHEL;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                    tmr_load  = 1'b1;
                    tmr_half  = 1'b1;
                end
            end
            START: begin
                if (tmr_done) begin
                    if (!sync2_q) begin
                        state_d  = SHIFT;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            SHIFT: begin
                if (tmr_done) begin
                    shreg_d  = {sync2_q, shreg_q[SHREG_W-1:1]};
                    tmr_load = 1'b1;
                    if (bit_cnt_q == nbits - BIT_CNT_W'(1)) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (tmr_done) begin
                    stop_d  = sync2_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                data_d  = {eight_q & aligned[7], aligned[6:0]};
                rxrdy_d = 1'b1;
                perr_d  = pen_q & (^aligned[6:0] ^ (eight_q & aligned[7]) ^ par_bit ^ ohel_q);
                ferr_d  = ~stop_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            baud_q    <= '0;
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            stop_q    <= 1'b0;
            data_q    <= 8'h00;
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= RX;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
            baud_q    <= baud_d;
            eight_q   <= eight_d;
            pen_q     <= pen_d;
            ohel_q    <= ohel_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            stop_q    <= stop_d;
            data_q    <= data_d;
            rxrdy_q   <= rxrdy_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

`ifdef UART_RX_OVERRUN_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (READ && rxrdy_q) ovf_d = 1'b0;
        if (state_q == DONE) ovf_d = rxrdy_q && !READ;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign OVF = ovf_q;
`else
    assign OVF = 1'b0;
`endif

    assign DATA  = data_q;
    assign RXRDY = rxrdy_q;
    assign PERR  = perr_q;
    assign FERR  = ferr_q;

endmodule
